// File: rtl/div_radix2.sv
// -----------------------------------------------------------------------------
// div_radix2 -- iterative radix-2 restoring divider for the execute stage.
//
// Handles DIV (signed) and DIVU (unsigned). While a divide is in flight the
// block requests an E-stage stall. Afterwards it holds quotient/remainder
// valid for HI/LO until the pipeline advances (ack). An exception flush
// aborts it at any point.
//
// Signed operands are reduced to magnitudes. The unsigned core then produces
// one quotient bit per cycle, and a final FIX cycle restores the signs. The
// quotient takes the sign a^b and the remainder takes the sign of a.
//
// Ports:
//   clk        in   pipeline clock, rising edge
//   resetn     in   asynchronous active-low reset
//   start      in   a valid DIV/DIVU occupies E (level, held until E advances)
//   is_signed  in   1 = DIV, 0 = DIVU; sampled with start in IDLE
//   a, b       in   dividend / divisor; sampled in IDLE
//   flush      in   exception flush of E; aborts any operation
//   ack        in   E stage advances this cycle (releases DONE)
//   stall      out  stall request to the hazard unit (combinational)
//   valid      out  result held valid (state DONE)
//   quotient   out  to LO
//   remainder  out  to HI
// -----------------------------------------------------------------------------
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             ack,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int               CNT_W    = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_divisor;  // divisor magnitude
    logic [WIDTH-1:0] r_quo;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic             r_sign_q;
    logic             r_sign_r;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_partial;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    // Operand magnitudes. Unsigned operands are never treated as negative.
    // The magnitude of the most negative value is itself, read as unsigned,
    // so the overflow case needs no special handling.
    assign w_a_neg = is_signed & a[WIDTH-1];
    assign w_b_neg = is_signed & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Restoring step. The partial remainder is always below the divisor, so
    // {rem, next dividend bit} is below 2*divisor. The WIDTH+1-bit difference
    // therefore never overflows, and its MSB is the borrow (negative result).
    assign w_partial = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_partial - {1'b0, r_divisor};
    assign w_fits    = ~w_trial[WIDTH];

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first, so no path leaves the signal
        // unassigned and no latch is inferred.
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next_state = (b == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == LAST_CNT) begin
                        w_next_state = S_FIX;
                    end
                end
                S_FIX:   w_next_state = S_DONE;
                S_DONE: begin
                    if (ack) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // stall is combinational on start/flush, so the instruction is held in E
    // from its first E cycle, and a flush releases E in the same cycle.
    always_comb begin
        valid = (r_state == S_DONE);
        stall = start & ~flush & (r_state != S_DONE);
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    // NOTE: the datapath is reset as well because quotient/remainder must
    // read zero straight out of reset; there is no array here to worry about.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_divisor <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            // Locally defined divide-by-zero result.
                            r_quo <= '1;
                            r_rem <= a;
                        end else begin
                            r_quo     <= w_a_mag;
                            r_divisor <= w_b_mag;
                            r_rem     <= '0;
                            r_sign_q  <= w_a_neg ^ w_b_neg;
                            r_sign_r  <= w_a_neg;
                            r_cnt     <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_partial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_fits};
                    if (r_cnt != LAST_CNT) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (r_sign_q) begin
                        r_quo <= -r_quo;
                    end
                    if (r_sign_r) begin
                        r_rem <= -r_rem;
                    end
                end
                default: begin
                    // DONE: result frozen
                end
            endcase
        end
    end

endmodule

// File: doc/div_radix2.md
# div_radix2

Iterative radix-2 restoring divider for the execute stage of the dual-issue pipeline. It produces the `alu_stallE` request that the hazard unit consumes: it holds the E stage while a DIV/DIVU is in flight, then presents a held quotient/remainder for HI/LO until the pipeline advances. It honours exception flushes by aborting mid-operation.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; a valid DIV/DIVU occupies E. Held high until the instruction leaves E.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; sampled with `start` in IDLE.
- `a`  in  WIDTH  dividend; sampled in IDLE.
- `b`  in  WIDTH  divisor; sampled in IDLE.
- `flush`  in  1  exception flush of E; aborts any operation.
- `ack`  in  1  E stage advances this cycle; must not depend on `stall`.
- `stall`  out  1  to the hazard unit, ORed into `alu_stallE`.
- `valid`  out  1  result held valid (state DONE).
- `quotient`  out  WIDTH  to LO.
- `remainder`  out  WIDTH  to HI.

## Operation
- States: IDLE, RUN, FIX, DONE. Counter `cnt` is 5 bits.
- IDLE:
  - If `start & ~flush & b==0`: go to DONE with quotient = all ones and remainder = `a`. This result is defined by us, not by the ISA.
  - If `start & ~flush & b!=0`: latch `|a|`, `|b|` (magnitudes only when `is_signed`), `sign_q = a[W-1]^b[W-1]` and `sign_r = a[W-1]` (both forced to 0 when unsigned). Clear the partial remainder and set `cnt=0`. Go to RUN.
- RUN, one quotient bit per cycle:
  - Form `{rem, dividend_msb}`, a WIDTH+1-bit value.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep the difference and shift in 1; otherwise keep the value and shift in 0.
  - When `cnt==WIDTH-1`, go to FIX; otherwise increment `cnt`.
- FIX:
  - Quotient is negated if `sign_q`.
  - Remainder is negated if `sign_r`.
  - Go to DONE.
- DONE:
  - `valid=1`; outputs are frozen.
  - `ack` causes DONE → IDLE. Without `ack`, stay in DONE indefinitely (the pipeline is stalled by another cause).
- Overflow case: signed `0x80000000 / 0xFFFFFFFF` gives q=`0x80000000`, r=0. This falls out of the unsigned magnitude path plus negation wrap; no special case.
- `stall = start & ~flush & (state != DONE)`. This is combinational, so the instruction is held in E from its first E cycle.
- `flush` from any state: next state IDLE, `valid` cleared. `quotient`/`remainder` need not be cleared.
- `flush` with `start` in IDLE: no operation starts.
- `ack` outside DONE is ignored.
- `start` low in RUN/FIX without `flush` cannot legally occur, because `stall` holds E. The behaviour is to continue to DONE, then wait for `ack`.
- Reset: state IDLE, `cnt=0`, `valid=0`, `stall=0` (given `start` low), `quotient=0`, `remainder=0`.

## Timing
- Cycle 0 is the first cycle `start` is high in IDLE.
- Normal division:
  - `stall` is high in cycles 0..33: cycle 0 in IDLE, cycles 1..32 in RUN, cycle 33 in FIX.
  - Cycle 34: DONE, `valid=1`, `stall=0`. The pipeline may assert `ack` in that cycle, and the result is captured on that edge.
  - Total added latency is 34 cycles.
- Divide by zero: `stall` high in cycle 0 only; `valid` in cycle 1.
- Back-to-back divides: DONE+`ack` → IDLE. The next `start` begins the following cycle, and `stall` is asserted combinationally in that cycle.
- `flush` takes effect the same cycle for `stall` (combinational) and on the next edge for state.
- Asynchronous reset mid-RUN: all outputs are at reset values immediately, with no edge required.

## Test plan
- Unsigned 100/7, `start` held, `ack` tied to `~stall`: `stall` high for 34 cycles, then `valid` with q=14, r=2.
- Signed −7/2 (`0xFFFFFFF9`/`2`): q=`0xFFFFFFFD`, r=`0xFFFFFFFF`. Signed 7/−2: q=`0xFFFFFFFD`, r=1. Unsigned `0xFFFFFFFF`/1: q=`0xFFFFFFFF`, r=0.
- Signed `0x80000000`/`0xFFFFFFFF`: q=`0x80000000`, r=0, no hang. Signed or unsigned 1234/0: `valid` at cycle 1 with q=`0xFFFFFFFF`, r=1234.
- Abort and DONE hold:
  - Assert `flush` at cycle 10: `stall` drops that cycle, state is IDLE next cycle. A fresh 100/7 then completes correctly in 34 cycles with no stale bits.
  - In DONE, hold `ack` low for 5 cycles: `valid`, q and r stay stable and `stall=0`. Pulse `ack`: IDLE next cycle.
- Deassert `resetn` at cycle 15 of RUN: `valid=0`, q=r=0 immediately. After release, a new 9/3 yields q=3, r=0.
- Random signed and unsigned operands (10k) against a reference model, with `ack` delays of 0–3 cycles. Check results and the exact 34-cycle `stall` width.
